// File: rtl/shift_pkg.sv
// Shared types for the shift-register transmitter/receiver pair.
// State encoding and counter sizing helper.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // $clog2 floored at one bit so a count of 1 still gets a register
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_shift_tx_if.sv
// Parallel word handshake into the shift transmitter.
// Source drives data/valid, transmitter answers with ready.
interface piso_shift_tx_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/shift_reg_core.sv
// Loadable shift register, shifting toward the output end.
// Shared by the transmitter and the matching receiver.
module shift_reg_core
  import shift_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] din,
  output logic             nxt_bit
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= MSB_FIRST ? {q[WIDTH-2:0], ser_in}
                     : {ser_in, q[WIDTH-1:1]};
    end
  end

  // bit that reaches the output end on the next shift
  assign nxt_bit = MSB_FIRST ? q[WIDTH-2] : q[1];

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter with frame strobe,
// done pulse, abort and a forced idle gap after each frame.
module piso_shift_tx
  import shift_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic     Clk,
  input  logic     clr,
  piso_shift_tx_if.slave in_if,
  input  logic     abort,
  output logic     ser_out,
  output logic     frame,
  output logic     tx_done,
  output logic     busy
);

  localparam int BW = cnt_w(WIDTH);
  localparam int GW = cnt_w(GAP_CYCLES + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

  state_t        state;
  logic [BW-1:0] bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic          accept;
  logic          last_bit;
  logic          shift;
  logic          nxt_bit;
  logic          first_bit;

  assign in_if.in_ready = (state == IDLE);

  assign accept   = (state == IDLE) && in_if.in_valid && !abort;
  assign last_bit = (bit_cnt == '0);
  assign shift    = (state == SHIFT) && !abort && !last_bit;

  assign first_bit = MSB_FIRST ? in_if.in_data[WIDTH-1]
                               : in_if.in_data[0];

  shift_reg_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk     (Clk),
    .rst_n   (clr),
    .load    (accept),
    .shift   (shift),
    .ser_in  (1'b0),
    .din     (in_if.in_data),
    .nxt_bit (nxt_bit)
  );

  always_ff @(posedge Clk or negedge clr) begin
    if (!clr) begin
      state   <= IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
      ser_out <= IDLE_LEVEL;
      frame   <= 1'b0;
      tx_done <= 1'b0;
      busy    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state   <= SHIFT;
            bit_cnt <= BIT_LAST;
            ser_out <= first_bit;
            frame   <= 1'b1;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          if (abort || last_bit) begin
            ser_out <= IDLE_LEVEL;
            frame   <= 1'b0;
            tx_done <= 1'b0;
            if (!abort && GAP_CYCLES > 0) begin
              state   <= GAP;
              gap_cnt <= GAP_LAST;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt - BIT_ONE;
            ser_out <= nxt_bit;
            // pulse lands on the cycle carrying the final bit
            tx_done <= (bit_cnt == BIT_ONE);
          end
        end
        GAP: begin
          if (abort || gap_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: three configurations checked every
// cycle against a frame-queue model plus literal expectations.
module tb_piso_shift_tx;

  localparam int W = 8;

  typedef struct packed {
    logic ser;
    logic frm;
    logic dn;
  } ent_t;

  logic Clk = 1'b0;
  logic clr = 1'b0;

  logic [W-1:0] d  [3];
  logic         v  [3];
  logic         ab [3];
  logic [2:0]   so, fr, td, bz, rd;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  int msb [3] = '{1, 0, 1};
  int gap [3] = '{1, 1, 0};

  ent_t       mq   [3][16];
  int         mlen [3];
  ent_t       cur  [3];
  logic       mbusy[3];
  int         acc_n[3];
  int         acc_last[3];
  int         acc_prev[3];
  logic [7:0] cap  [3];
  int         fl   [3];
  logic [7:0] dw   [3][8];
  int         dn   [3];
  int         dfl  [3];
  int         lowc [3];
  int         lastlow[3];

  piso_shift_tx_if #(.WIDTH(W)) if0 ();
  piso_shift_tx_if #(.WIDTH(W)) if1 ();
  piso_shift_tx_if #(.WIDTH(W)) if2 ();

  assign if0.in_data  = d[0];
  assign if0.in_valid = v[0];
  assign rd[0]        = if0.in_ready;
  assign if1.in_data  = d[1];
  assign if1.in_valid = v[1];
  assign rd[1]        = if1.in_ready;
  assign if2.in_data  = d[2];
  assign if2.in_valid = v[2];
  assign rd[2]        = if2.in_ready;

  piso_shift_tx #(
    .WIDTH(W), .MSB_FIRST(1'b1),
    .GAP_CYCLES(1), .IDLE_LEVEL(1'b0)
  ) u0 (
    .Clk(Clk), .clr(clr), .in_if(if0), .abort(ab[0]),
    .ser_out(so[0]), .frame(fr[0]),
    .tx_done(td[0]), .busy(bz[0])
  );

  piso_shift_tx #(
    .WIDTH(W), .MSB_FIRST(1'b0),
    .GAP_CYCLES(1), .IDLE_LEVEL(1'b0)
  ) u1 (
    .Clk(Clk), .clr(clr), .in_if(if1), .abort(ab[1]),
    .ser_out(so[1]), .frame(fr[1]),
    .tx_done(td[1]), .busy(bz[1])
  );

  piso_shift_tx #(
    .WIDTH(W), .MSB_FIRST(1'b1),
    .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)
  ) u2 (
    .Clk(Clk), .clr(clr), .in_if(if2), .abort(ab[2]),
    .ser_out(so[2]), .frame(fr[2]),
    .tx_done(td[2]), .busy(bz[2])
  );

  initial forever #5 Clk = ~Clk;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic ent_t idle_e();
    return '{ser: 1'b0, frm: 1'b0, dn: 1'b0};
  endfunction

  task automatic pop(input int i);
    cur[i] = mq[i][0];
    for (int k = 0; k < 15; k++) mq[i][k] = mq[i][k+1];
    mlen[i]--;
  endtask

  // Word-level model: an accepted word becomes a queue of
  // per-cycle outputs (W bits then the gap), one per edge.
  task automatic model_step(input int i);
    logic [W-1:0] w;
    if (mbusy[i]) begin
      if (ab[i]) begin
        mlen[i]  = 0;
        mbusy[i] = 1'b0;
        cur[i]   = idle_e();
      end else if (mlen[i] > 0) begin
        pop(i);
      end else begin
        mbusy[i] = 1'b0;
        cur[i]   = idle_e();
      end
    end else if (v[i] && !ab[i]) begin
      w = d[i];
      for (int k = 0; k < W; k++) begin
        mq[i][k] = '{ser: (msb[i] != 0) ? w[W-1-k] : w[k],
                     frm: 1'b1, dn: (k == W-1)};
      end
      for (int g = 0; g < gap[i]; g++) mq[i][W+g] = idle_e();
      mlen[i] = W + gap[i];
      pop(i);
      mbusy[i]    = 1'b1;
      acc_prev[i] = acc_last[i];
      acc_last[i] = cyc;
      acc_n[i]++;
    end else begin
      cur[i] = idle_e();
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      mlen[i] = 0; mbusy[i] = 1'b0; cur[i] = idle_e();
      acc_n[i] = 0; acc_last[i] = 0; acc_prev[i] = 0;
      cap[i] = '0; fl[i] = 0; dn[i] = 0; dfl[i] = 0;
      lowc[i] = 0; lastlow[i] = 0;
    end
    forever begin
      @(negedge Clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
        if (!clr) begin
          mlen[i]  = 0;
          mbusy[i] = 1'b0;
          cur[i]   = idle_e();
        end else begin
          model_step(i);
        end
        chk($sformatf("u%0d cyc%0d {ser,frm,done,busy,rdy}",
                      i, cyc),
            {27'd0, so[i], fr[i], td[i], bz[i], rd[i]},
            {27'd0, cur[i].ser, cur[i].frm, cur[i].dn,
             mbusy[i], !mbusy[i]});
        if (fr[i]) begin
          if (lowc[i] > 0) lastlow[i] = lowc[i];
          lowc[i] = 0;
          cap[i]  = {cap[i][W-2:0], so[i]};
          fl[i]++;
          if (td[i]) begin
            dw[i][dn[i] % 8] = cap[i];
            dfl[i] = fl[i];
            dn[i]++;
          end
        end else begin
          fl[i] = 0;
          lowc[i]++;
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge Clk);
      #1;
    end
  endtask

  task automatic wait_acc(input int i);
    int n0;
    int k;
    n0 = acc_n[i];
    k  = 0;
    while (acc_n[i] == n0 && k < 40) begin
      step();
      k++;
    end
    chk($sformatf("u%0d accept seen", i),
        32'(acc_n[i] != n0), 32'd1);
  endtask

  task automatic wait_done(input int i);
    int n0;
    int k;
    n0 = dn[i];
    k  = 0;
    while (dn[i] == n0 && k < 40) begin
      step();
      k++;
    end
    chk($sformatf("u%0d done seen", i),
        32'(dn[i] != n0), 32'd1);
  endtask

  function automatic logic [7:0] lastw(input int i,
                                       input int back);
    return dw[i][(dn[i] - back) % 8];
  endfunction

  task automatic send(input int i, input logic [7:0] w);
    d[i] = w;
    v[i] = 1'b1;
    wait_acc(i);
    v[i] = 1'b0;
  endtask

  initial begin
    int a;
    int n0;
    for (int i = 0; i < 3; i++) begin
      d[i] = '0; v[i] = 1'b0; ab[i] = 1'b0;
    end
    clr = 1'b0;
    step(3);
    chk("reset ready", 32'(rd[0]), 32'd1);
    chk("reset frame", 32'(fr), 32'd0);
    chk("reset busy", 32'(bz), 32'd0);
    chk("reset ser", 32'(so), 32'd0);
    clr = 1'b1;
    step(2);

    // MSB-first basic frame
    d[0] = 8'hA5;
    v[0] = 1'b1;
    wait_acc(0);
    v[0] = 1'b0;
    chk("A5 latency frame", 32'(fr[0]), 32'd1);
    chk("A5 first bit", 32'(so[0]), 32'd1);
    wait_done(0);
    chk("A5 word", 32'(lastw(0, 1)), 32'hA5);
    chk("A5 frame len", 32'(dfl[0]), 32'd8);
    step();
    chk("A5 gap ready", 32'(rd[0]), 32'd0);
    chk("A5 gap frame", 32'(fr[0]), 32'd0);
    step();
    chk("A5 idle ready", 32'(rd[0]), 32'd1);

    // LSB-first
    send(1, 8'h01);
    wait_done(1);
    chk("lsb 01 word", 32'(lastw(1, 1)), 32'h80);
    send(1, 8'h80);
    wait_done(1);
    chk("lsb 80 word", 32'(lastw(1, 1)), 32'h01);

    // back-to-back, data changed mid-shift
    d[0] = 8'h3C;
    v[0] = 1'b1;
    wait_acc(0);
    d[0] = 8'hC3;
    wait_acc(0);
    v[0] = 1'b0;
    chk("b2b period g1", 32'(acc_last[0] - acc_prev[0]), 32'd10);
    wait_done(0);
    chk("b2b word1", 32'(lastw(0, 2)), 32'h3C);
    chk("b2b word2", 32'(lastw(0, 1)), 32'hC3);
    chk("b2b low g1", 32'(lastlow[0]), 32'd2);

    d[2] = 8'h3C;
    v[2] = 1'b1;
    wait_acc(2);
    d[2] = 8'hC3;
    wait_acc(2);
    v[2] = 1'b0;
    chk("b2b period g0", 32'(acc_last[2] - acc_prev[2]), 32'd9);
    wait_done(2);
    chk("g0 word1", 32'(lastw(2, 2)), 32'h3C);
    chk("g0 word2", 32'(lastw(2, 1)), 32'hC3);
    chk("b2b low g0", 32'(lastlow[2]), 32'd1);

    // input stability and valid pulse during gap
    send(0, 8'h5A);
    d[0] = 8'hFF;
    wait_done(0);
    chk("stable word", 32'(lastw(0, 1)), 32'h5A);
    a = acc_n[0];
    step();
    v[0] = 1'b1;
    step();
    v[0] = 1'b0;
    step(3);
    chk("gap pulse no accept", 32'(acc_n[0]), 32'(a));

    // abort on the 4th bit
    send(0, 8'hFF);
    step(3);
    chk("abort 4th bit on", 32'(fr[0]), 32'd1);
    n0 = dn[0];
    ab[0] = 1'b1;
    step();
    ab[0] = 1'b0;
    chk("abort frame", 32'(fr[0]), 32'd0);
    chk("abort ser", 32'(so[0]), 32'd0);
    chk("abort busy", 32'(bz[0]), 32'd0);
    chk("abort ready", 32'(rd[0]), 32'd1);
    step(3);
    chk("abort no done", 32'(dn[0]), 32'(n0));

    // abort beats valid in idle
    a = acc_n[0];
    d[0] = 8'h11;
    ab[0] = 1'b1;
    v[0] = 1'b1;
    step(2);
    ab[0] = 1'b0;
    v[0] = 1'b0;
    chk("idle abort no accept", 32'(acc_n[0]), 32'(a));
    chk("idle abort busy", 32'(bz[0]), 32'd0);

    // async reset mid-frame
    send(1, 8'hF0);
    n0 = dn[1];
    step(2);
    @(negedge Clk);
    #3;
    clr = 1'b0;
    #1;
    chk("async ser", 32'(so[1]), 32'd0);
    chk("async frame", 32'(fr[1]), 32'd0);
    chk("async busy", 32'(bz[1]), 32'd0);
    chk("async ready", 32'(rd[1]), 32'd1);
    step(2);
    clr = 1'b1;
    step(12);
    chk("async no done", 32'(dn[1]), 32'(n0));
    send(1, 8'h96);
    wait_done(1);
    chk("post reset word", 32'(lastw(1, 1)), 32'h69);
    chk("post reset len", 32'(dfl[1]), 32'd8);
    step(3);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
- Parallel-in/serial-out shift-register transmitter: the transmit end paired with the team's serial-in shift-register receivers.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock with a frame strobe.
- Inserts a configurable idle gap after each frame.
- Sits between a parallel data source and a serial link inside the register/shift-register study designs.

Parameters:
- WIDTH, 8, bits per frame (must be >= 2).
- MSB_FIRST, 1, 1 = bit WIDTH-1 goes out first; 0 = bit 0 goes out first.
- GAP_CYCLES, 1, idle cycles forced after each frame (>= 0).
- IDLE_LEVEL, 0, value driven on ser_out when not framing.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  parallel word to transmit.
- in_valid  input  1  source has a word on in_data.
- in_ready  output  1  block can accept a word this cycle.
- abort  input  1  synchronous frame cancel.
- ser_out  output  1  serial data.
- frame  output  1  high while ser_out carries a valid data bit.
- tx_done  output  1  one-cycle pulse coincident with the last data bit.
- busy  output  1  high in SHIFT or GAP.

Behaviour:
- Reset:
  - clr low forces the following immediately, independent of Clk: state=IDLE, shift register=0, bit counter=0, gap counter=0, ser_out=IDLE_LEVEL, frame=0, tx_done=0, busy=0.
  - in_ready equals (state==IDLE), so it reads 1 while in reset.
  - Release is synchronous to the first rising edge with clr high.
  - Reset mid-frame aborts the frame: no tx_done, no partial bits afterwards.
- Outputs: ser_out, frame, tx_done and busy are registered (no combinational path from inputs). in_ready is decoded from state only.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at a rising edge: load in_data into the shift register, set bit counter to WIDTH-1, go to SHIFT.
  - in_data is sampled only at the accepting edge; later changes are ignored.
- SHIFT:
  - The first bit appears on ser_out with frame=1 in the cycle after acceptance (latency 1 cycle).
  - Each rising edge presents the next bit and decrements the counter.
  - The bit order is MSB_FIRST-selected; the register shifts toward the output end and zero-fills.
  - Exactly WIDTH consecutive frame=1 cycles per word.
  - tx_done=1 only in the cycle carrying the final bit.
  - After the final bit: go to GAP if GAP_CYCLES>0, else go to IDLE.
- GAP:
  - frame=0, ser_out=IDLE_LEVEL, in_ready=0.
  - Holds for exactly GAP_CYCLES cycles, then goes to IDLE.
- Throughput: one word per WIDTH+GAP_CYCLES+1 cycles (includes one IDLE acceptance cycle). No back-to-back acceptance during SHIFT.
- abort:
  - In SHIFT or GAP: next edge goes to IDLE, frame=0, ser_out=IDLE_LEVEL, no tx_done. The gap is skipped.
  - In IDLE: abort has priority over in_valid; no word is accepted that cycle.
  - abort in the final SHIFT cycle suppresses the tx_done that would have followed. The bit already on ser_out remains valid.
- in_valid outside IDLE is ignored (handshake not completed). The source must hold in_data/in_valid until in_ready.
- Counter widths: bit counter is $clog2(WIDTH) bits; gap counter is $clog2(GAP_CYCLES+1) bits.
- Counters wrap never; terminal counts are explicitly decoded.

Decomposition:
- Shared package (shift_pkg):
  - state enum {IDLE, SHIFT, GAP} with 2-bit encoding.
  - Helper function for counter width.
- One natural sub-module: shift_reg_core.
  - WIDTH-bit loadable shift register: parallel load, shift with direction select, async active-low clr.
  - Reusable by the matching receiver.
- FSM and counters stay in piso_shift_tx.

Test Plan:
- Basic frame: WIDTH=8, MSB_FIRST=1, GAP_CYCLES=1. Apply clr pulse, then send 0xA5 -> ser_out 1,0,1,0,0,1,0,1 on 8 consecutive frame=1 cycles starting 1 cycle after accept. tx_done on the 8th cycle, then 1 gap cycle, then in_ready=1.
- LSB-first: MSB_FIRST=0, send 0x01 -> first bit 1, remaining seven 0. The word 0x80 gives seven 0s then 1.
- Back-to-back: in_valid held high with 0x3C then 0xC3 -> second accept exactly WIDTH+GAP_CYCLES+1 cycles after the first; no overlap of frame. With GAP_CYCLES=0, frame drops for exactly 1 cycle.
- Input stability: change in_data during SHIFT, and pulse in_valid during GAP -> transmitted bits match the accepted word; no extra accept.
- Abort: assert abort on the 4th bit of 0xFF -> frame=0 next cycle, no tx_done, in_ready=1 the following cycle. Abort together with in_valid in IDLE -> no accept.
- Async reset: drive clr low mid-frame between clock edges -> ser_out=IDLE_LEVEL, frame=0, busy=0 immediately. After release, the next word transmits cleanly.
